// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: round-robin arbiter between two packet sources that serializes
// the granted packet LSB-first into the encoder, then drains the stuffer and runs EOP.
module usb_tx_scheduler #(
  parameter int LEN_W = 7
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_0,
  input  logic             req_1,
  input  logic [LEN_W-1:0] len_0,
  input  logic [LEN_W-1:0] len_1,
  input  logic [7:0]       byte_0,
  input  logic [7:0]       byte_1,
  output logic [1:0]       grant,
  output logic             byte_pop,
  output logic             enc_valid,
  output logic             enc_bit,
  input  logic             enc_ready,
  input  logic             enc_busy,
  output logic             eop_start,
  input  logic             eop_done,
  output logic             done,
  output logic             len_err
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_EOP    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             eop_start_q, eop_start_d;
  logic             done_q, done_d;
  logic             len_err_q, len_err_d;
  logic             pop;
  logic             win_1;
  logic [LEN_W-1:0] win_len;
  logic [7:0]       cur_byte;

  // On a tie the requester that was not served last wins.
  assign win_1    = req_1 & (~req_0 | ~last_q);
  assign win_len  = win_1 ? len_1 : len_0;
  assign cur_byte = grant_q[1] ? byte_1 : byte_0;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    eop_start_d = 1'b0;
    done_d      = 1'b0;
    len_err_d   = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q blocks the cycle in which a zero-length requester is still dropping req.
        if ((req_0 | req_1) && !done_q) begin
          if (win_len == '0) begin
            len_err_d = 1'b1;
            done_d    = 1'b1;
            last_d    = win_1;
          end else begin
            grant_d    = {win_1, ~win_1};
            byte_cnt_d = win_len;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        shreg_d   = cur_byte;
        pop       = 1'b1;
        bit_cnt_d = 3'd0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (enc_ready) begin
          if (bit_cnt_q != 3'd7) begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (byte_cnt_q > LEN_W'(1)) begin
            shreg_d    = cur_byte;
            pop        = 1'b1;
            byte_cnt_d = byte_cnt_q - LEN_W'(1);
            bit_cnt_d  = 3'd0;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!enc_busy) begin
          eop_start_d = 1'b1;
          state_d     = S_EOP;
        end
      end
      S_EOP: begin
        if (eop_done) begin
          done_d  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        grant_d = 2'b00;
        last_d  = grant_q[1];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= 3'd0;
      eop_start_q <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      eop_start_q <= eop_start_d;
      done_q      <= done_d;
      len_err_q   <= len_err_d;
    end
  end

  // Shift data needs no reset: enc_bit is masked outside SHIFT.
  always_ff @(posedge clock) begin
    shreg_q <= shreg_d;
  end

  assign grant     = grant_q;
  assign byte_pop  = pop;
  assign enc_valid = (state_q == S_SHIFT);
  assign enc_bit   = (state_q == S_SHIFT) & shreg_q[0];
  assign eop_start = eop_start_q;
  assign done      = done_q;
  assign len_err   = len_err_q;
endmodule
